ltc2308_responder: RTL and testbench



---
 rtl/ltc2308_responder_pkg.sv | 31 +++
 rtl/ltc2308_responder_if.sv | 10 +
 rtl/ltc2308_responder_convert.sv | 53 +++++
 rtl/ltc2308_responder.sv | 215 +++++++++++++++++++++
 tb/tb_ltc2308_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ltc2308_responder_pkg.sv
// Shared constants and types for the LTC2308 slave emulator.
package ltc2308_responder_pkg;

  localparam int DATA_W = 12;
  localparam int NUM_CH = 8;
  localparam int CFG_W  = 6;

  // Bit positions inside the 6-bit config word {S/D,O/S,S1,S0,UNI,SLP}
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // Single-ended CH0, unipolar, no sleep
  localparam logic [CFG_W-1:0] RESET_CFG_DEF = 6'b100010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONV     = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_SHIFT    = 2'd3
  } state_e;

  // Channel number selected by a config word: {S1,S0,O/S}
  function automatic logic [2:0] cfg_channel(input logic [CFG_W-1:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

endpackage

// File: rtl/ltc2308_responder_if.sv
// ADC serial wires between the sampling master and the emulated converter.
interface ltc2308_responder_if;
  logic ADC_CONVST;
  logic ADC_SCK;
  logic ADC_SDI;
  logic ADC_SDO;

  modport master (output ADC_CONVST, output ADC_SCK, output ADC_SDI, input ADC_SDO);
  modport slave  (input ADC_CONVST, input ADC_SCK, input ADC_SDI, output ADC_SDO);
endinterface

// File: rtl/ltc2308_responder_convert.sv
// Combinational conversion: channel mux, differential subtraction, clamp, output coding.
module ltc2308_responder_convert
  import ltc2308_responder_pkg::*;
(
  input  logic [DATA_W*NUM_CH-1:0] ch_data,
  input  logic [CFG_W-1:0]         cfg,
  output logic [DATA_W-1:0]        result
);

  logic [2:0]        ch_s;
  logic [2:0]        pair_ch_s;
  logic [DATA_W-1:0] sel_s;
  logic [DATA_W-1:0] pair_s;
  logic signed [13:0] v_s;

  // Select the sample(s) and map the signed value onto the 12-bit output code
  always_comb begin
    ch_s      = cfg_channel(cfg);
    pair_ch_s = ch_s ^ 3'd1;
    sel_s     = ch_data[DATA_W*ch_s +: DATA_W];
    pair_s    = ch_data[DATA_W*pair_ch_s +: DATA_W];
    result    = 12'd0;

    if (cfg[CFG_SD]) begin
      v_s = $signed({2'b00, sel_s});
    end else begin
      v_s = $signed({2'b00, sel_s}) - $signed({2'b00, pair_s});
    end

    if (cfg[CFG_UNI]) begin
      // Unipolar: negative differential inputs read as zero
      if (v_s < 14'sd0) begin
        result = 12'd0;
      end else if (v_s > 14'sd4095) begin
        result = 12'hFFF;
      end else begin
        result = v_s[11:0];
      end
    end else if (cfg[CFG_SD]) begin
      // Single-ended bipolar is offset binary around mid-scale
      result = {~sel_s[11], sel_s[10:0]};
    end else begin
      if (v_s < -14'sd2048) begin
        result = 12'h800;
      end else if (v_s > 14'sd2047) begin
        result = 12'h7FF;
      end else begin
        result = v_s[11:0];
      end
    end
  end

endmodule

// File: rtl/ltc2308_responder.sv
// LTC2308 slave emulator: samples CONVST/SCK/SDI on adc_clk and answers on SDO.
module ltc2308_responder
  import ltc2308_responder_pkg::*;
#(
  parameter int               CONV_CYCLES = 64,
  parameter logic [CFG_W-1:0] RESET_CFG   = RESET_CFG_DEF,
  parameter int               SYNC_STAGES = 2
)(
  input  logic                     adc_clk,
  input  logic                     rst,
  ltc2308_responder_if.slave       adc,
  input  logic [DATA_W*NUM_CH-1:0] ch_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic [CFG_W-1:0]         cfg_word,
  output logic [DATA_W-1:0]        result,
  output logic [15:0]              conv_count,
  output logic                     proto_err
);

  localparam int CNT_W = $clog2(CONV_CYCLES) + 1;

  // Input synchronizers plus one edge-detect flop per clock-like input
  logic [SYNC_STAGES-1:0] convst_sync_r, sck_sync_r, sdi_sync_r;
  logic convst_prev_r, sck_prev_r;
  logic convst_s, convst_rise_s, convst_fall_s, sck_rise_s, sck_fall_s, sdi_s;

  // FSM and datapath registers with their next-state values
  state_e             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [3:0]         bit_idx_r, bit_idx_s;
  logic               bits_done_r, bits_done_s;
  logic [CFG_W-1:0]   pend_r, pend_s;
  logic [2:0]         pcnt_r, pcnt_s;
  logic [CFG_W-1:0]   cfg_r, cfg_s, cfg_eff_s;
  logic [DATA_W-1:0]  sample_r, sample_s, result_r, result_s, conv_val_s;
  logic               sdo_r, sdo_s, busy_r, busy_s, frame_done_r, frame_done_s;
  logic [15:0]        count_r, count_s;
  logic               err_r, err_s, start_s;

  assign convst_s      = convst_sync_r[SYNC_STAGES-1];
  assign sdi_s         = sdi_sync_r[SYNC_STAGES-1];
  assign convst_rise_s = convst_s & ~convst_prev_r;
  assign convst_fall_s = ~convst_s & convst_prev_r;
  assign sck_rise_s    = sck_sync_r[SYNC_STAGES-1] & ~sck_prev_r;
  assign sck_fall_s    = ~sck_sync_r[SYNC_STAGES-1] & sck_prev_r;

  // Bring the asynchronous master wires into the adc_clk domain
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      convst_sync_r <= '0;
      sck_sync_r    <= '0;
      sdi_sync_r    <= '0;
      convst_prev_r <= 1'b0;
      sck_prev_r    <= 1'b0;
    end else begin
      convst_sync_r <= {convst_sync_r[SYNC_STAGES-2:0], adc.ADC_CONVST};
      sck_sync_r    <= {sck_sync_r[SYNC_STAGES-2:0], adc.ADC_SCK};
      sdi_sync_r    <= {sdi_sync_r[SYNC_STAGES-2:0], adc.ADC_SDI};
      convst_prev_r <= convst_sync_r[SYNC_STAGES-1];
      sck_prev_r    <= sck_sync_r[SYNC_STAGES-1];
    end
  end

  // Config used by a conversion starting now: a complete 6-bit word from the last frame wins
  always_comb begin
    if (pcnt_r == 3'd6) begin
      cfg_eff_s = pend_r;
    end else begin
      cfg_eff_s = cfg_r;
    end
  end

  ltc2308_responder_convert u_convert (
    .ch_data (ch_data),
    .cfg     (cfg_eff_s),
    .result  (conv_val_s)
  );

  // Protocol FSM next-state and datapath updates
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    bit_idx_s    = bit_idx_r;
    bits_done_s  = bits_done_r;
    pend_s       = pend_r;
    pcnt_s       = pcnt_r;
    cfg_s        = cfg_r;
    sample_s     = sample_r;
    result_s     = result_r;
    sdo_s        = sdo_r;
    count_s      = count_r;
    err_s        = err_r;
    frame_done_s = 1'b0;
    start_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        start_s = convst_rise_s;
      end
      ST_CONV: begin
        // The master must stay quiet while the converter is busy
        if (sck_rise_s || sck_fall_s || convst_fall_s) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        if (cnt_r == '0) begin
          result_s = sample_r;
          state_s  = ST_WAIT_LOW;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT_LOW: begin
        if (!convst_s) begin
          sdo_s       = result_r[11];
          bit_idx_s   = 4'd11;
          bits_done_s = 1'b0;
          pcnt_s      = 3'd0;
          state_s     = ST_SHIFT;
        end else begin
          state_s = ST_WAIT_LOW;
        end
      end
      ST_SHIFT: begin
        if (convst_rise_s) begin
          start_s = 1'b1;
        end else begin
          // Config bits are taken on SCK rises, only the first six count
          if (sck_rise_s && (pcnt_r < 3'd6)) begin
            pend_s = {pend_r[CFG_W-2:0], sdi_s};
            pcnt_s = pcnt_r + 3'd1;
          end else begin
            pcnt_s = pcnt_r;
          end
          // Result bits advance on SCK falls; after the LSB the line parks low
          if (sck_fall_s && !bits_done_r) begin
            if (bit_idx_r != 4'd0) begin
              bit_idx_s = bit_idx_r - 4'd1;
              sdo_s     = result_r[bit_idx_s];
            end else begin
              sdo_s        = 1'b0;
              bits_done_s  = 1'b1;
              frame_done_s = 1'b1;
            end
          end else begin
            bit_idx_s = bit_idx_r;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Conversion start is shared by IDLE and SHIFT
    if (start_s) begin
      cfg_s    = cfg_eff_s;
      sample_s = conv_val_s;
      count_s  = count_r + 16'd1;
      cnt_s    = CNT_W'(CONV_CYCLES - 1);
      pcnt_s   = 3'd0;
      state_s  = ST_CONV;
    end else begin
      cfg_s = cfg_r;
    end

    busy_s = (state_s == ST_CONV);
  end

  // State and output registers
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      bit_idx_r    <= 4'd0;
      bits_done_r  <= 1'b0;
      pend_r       <= '0;
      pcnt_r       <= 3'd0;
      cfg_r        <= RESET_CFG;
      sample_r     <= 12'd0;
      result_r     <= 12'd0;
      sdo_r        <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      count_r      <= 16'd0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      bit_idx_r    <= bit_idx_s;
      bits_done_r  <= bits_done_s;
      pend_r       <= pend_s;
      pcnt_r       <= pcnt_s;
      cfg_r        <= cfg_s;
      sample_r     <= sample_s;
      result_r     <= result_s;
      sdo_r        <= sdo_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      count_r      <= count_s;
      err_r        <= err_s;
    end
  end

  assign adc.ADC_SDO = sdo_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign cfg_word    = cfg_r;
  assign result      = result_r;
  assign conv_count  = count_r;
  assign proto_err   = err_r;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Self-checking bench for the LTC2308 slave emulator.
`timescale 1ns/1ps
module tb_ltc2308_responder;

  localparam int CONV_CYCLES = 64;
  localparam logic [5:0] RCFG = 6'b100010;

  logic        adc_clk = 1'b0;
  logic        rst;
  logic [95:0] ch_data;
  logic        busy, frame_done, proto_err;
  logic [5:0]  cfg_word;
  logic [11:0] result;
  logic [15:0] conv_count;

  ltc2308_responder_if adc ();

  ltc2308_responder #(
    .CONV_CYCLES (CONV_CYCLES),
    .RESET_CFG   (RCFG),
    .SYNC_STAGES (2)
  ) dut (
    .adc_clk    (adc_clk),
    .rst        (rst),
    .adc        (adc),
    .ch_data    (ch_data),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_word   (cfg_word),
    .result     (result),
    .conv_count (conv_count),
    .proto_err  (proto_err)
  );

  always #5 adc_clk = ~adc_clk;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;

  // Reference model state: what a real LTC2308 would hold
  logic [5:0]  m_cfg;
  logic [5:0]  m_pend;
  logic [11:0] m_result;
  int          m_count;
  bit          m_shift;
  int          m_bits;
  bit          m_err;

  typedef struct {
    logic [95:0] chd;
    logic [5:0]  cfg;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n cycles on the falling edge, counting frame_done pulses
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge adc_clk);
      if (frame_done === 1'b1) fd_cnt++;
    end
  endtask

  function automatic logic [11:0] ref_conv(input logic [95:0] d, input logic [5:0] c);
    int ch, s, o, v;
    ch = int'(c[3]) * 4 + int'(c[2]) * 2 + int'(c[4]);
    s  = int'(d[ch*12 +: 12]);
    o  = int'(d[(ch ^ 1)*12 +: 12]);
    if (c[5]) v = s; else v = s - o;
    if (c[1]) begin
      if (v < 0) v = 0;
      if (v > 4095) v = 4095;
    end else if (c[5]) begin
      v = s - 2048;
    end else begin
      if (v < -2048) v = -2048;
      if (v > 2047) v = 2047;
    end
    return v[11:0];
  endfunction

  task automatic model_reset();
    m_cfg = RCFG; m_pend = 6'd0; m_result = 12'd0; m_count = 0;
    m_shift = 1'b0; m_bits = 0; m_err = 1'b0;
  endtask

  // One SPI frame of n SCK pulses; sends cfg MSB first and checks the SDO word
  task automatic do_frame(input int n, input logic [5:0] cfg);
    logic [15:0] got, exp;
    got = 16'd0; exp = 16'd0; fd_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 6) adc.ADC_SDI = cfg[5-i];
      else       adc.ADC_SDI = 1'($urandom_range(0, 1));
      tick(4);
      adc.ADC_SCK = 1'b1;
      tick(4);
      got[15-i] = adc.ADC_SDO;
      if (i < 12) exp[15-i] = m_result[11-i];
      adc.ADC_SCK = 1'b0;
    end
    tick(8);
    if (m_shift) begin
      if (n >= 6) begin
        m_pend = cfg;
        m_bits = 6;
      end else begin
        m_bits = n;
      end
    end
    check("sdo_word", {16'd0, got}, {16'd0, exp});
    check("frame_done_pulses", fd_cnt, (m_shift && n >= 12) ? 1 : 0);
  endtask

  // CONVST high until busy drops, then low; optional SCK toggle during CONV
  task automatic do_convst(input bit glitch);
    bit seen;
    int bcnt;
    if (m_shift && m_bits == 6) m_cfg = m_pend;
    m_result = ref_conv(ch_data, m_cfg);
    m_count  = (m_count + 1) & 32'hFFFF;
    m_bits   = 0;
    if (glitch) m_err = 1'b1;
    adc.ADC_CONVST = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      seen = busy;
    end
    check("busy_rise", {31'd0, seen}, 32'd1);
    bcnt = seen ? 1 : 0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (glitch && bcnt == 10) adc.ADC_SCK = 1'b1;
      if (glitch && bcnt == 20) adc.ADC_SCK = 1'b0;
      tick(1);
      if (busy) bcnt++;
    end
    check("busy_len", bcnt, CONV_CYCLES);
    adc.ADC_CONVST = 1'b0;
    m_shift = 1'b1;
    tick(8);
    check("result", {20'd0, result}, {20'd0, m_result});
    check("cfg_word", {26'd0, cfg_word}, {26'd0, m_cfg});
    check("conv_count", {16'd0, conv_count}, m_count);
    check("proto_err", {31'd0, proto_err}, {31'd0, m_err});
  endtask

  initial begin
    tbl[0] = '{chd: {84'h0, 12'hABC},           cfg: 6'b100010, exp: 12'hABC};
    tbl[1] = '{chd: {72'h0, 12'h123, 12'h456},  cfg: 6'b100010, exp: 12'h456};
    tbl[2] = '{chd: {72'h0, 12'h123, 12'h456},  cfg: 6'b110010, exp: 12'h123};
    tbl[3] = '{chd: {72'h0, 12'h900, 12'h100},  cfg: 6'b000000, exp: 12'h800};
    tbl[4] = '{chd: {72'h0, 12'h900, 12'h100},  cfg: 6'b000010, exp: 12'h000};
    tbl[5] = '{chd: {84'h0, 12'h800},           cfg: 6'b100000, exp: 12'h000};
    tbl[6] = '{chd: {84'h0, 12'hFFF},           cfg: 6'b100000, exp: 12'h7FF};
    tbl[7] = '{chd: {72'h0, 12'h900, 12'h100},  cfg: 6'b010000, exp: 12'h7FF};
    tbl[8] = '{chd: {12'h5A5, 84'h0},           cfg: 6'b111111, exp: 12'h5A5};

    rst = 1'b1;
    adc.ADC_CONVST = 1'b0; adc.ADC_SCK = 1'b0; adc.ADC_SDI = 1'b0;
    ch_data = 96'd0;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_sdo", {31'd0, adc.ADC_SDO}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cfg", {26'd0, cfg_word}, {26'd0, RCFG});
    check("rst_result", {20'd0, result}, 32'd0);
    check("rst_count", {16'd0, conv_count}, 32'd0);
    check("rst_err", {31'd0, proto_err}, 32'd0);

    // Directed vectors: the frame before each CONVST carries that conversion's config
    for (int k = 0; k < 9; k++) begin
      ch_data = tbl[k].chd;
      do_frame(12, tbl[k].cfg);
      do_convst(1'b0);
      check("tbl_result", {20'd0, result}, {20'd0, tbl[k].exp});
      if (k == 1) check("count_two", {16'd0, conv_count}, 32'd2);
    end

    // SCK activity during CONV sets the sticky error
    ch_data = {$urandom(), $urandom(), $urandom()};
    do_frame(12, 6'b100010);
    do_convst(1'b1);
    do_frame(12, 6'b100110);
    do_convst(1'b0);

    // Short 4-bit frame keeps the config; 14-fall frame reads zeros past the LSB
    ch_data = {$urandom(), $urandom(), $urandom()};
    do_frame(4, 6'b011011);
    do_convst(1'b0);
    check("short_frame_cfg", {26'd0, cfg_word}, {26'd0, 6'b100110});
    do_frame(14, 6'b101010);
    do_convst(1'b0);

    // Randomized frames and configs against the model
    for (int r = 0; r < 24; r++) begin
      ch_data = {$urandom(), $urandom(), $urandom()};
      do_frame(int'($urandom_range(4, 16)), 6'($urandom_range(0, 63)));
      do_convst(1'b0);
    end

    // Reset in the middle of a frame
    do_frame(5, 6'b001101);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(1);
    check("mid_rst_sdo", {31'd0, adc.ADC_SDO}, 32'd0);
    check("mid_rst_cfg", {26'd0, cfg_word}, {26'd0, RCFG});
    check("mid_rst_count", {16'd0, conv_count}, 32'd0);
    check("mid_rst_err", {31'd0, proto_err}, 32'd0);
    ch_data = {72'h0, 12'h777, 12'h3C5};
    do_convst(1'b0);
    check("post_rst_ch0", {20'd0, result}, {20'd0, 12'h3C5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
